// File: rtl/intra_loop_pkg.sv
// Shared types and constants for the intra loop sequencer.
package intra_loop_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      EXTRACT,
      PREDICT,
      SAVE,
      ADVANCE
   } seq_state_t;

   // Reconstructor phase enables, one-hot or all clear.
   localparam logic [2:0] EN_NONE    = 3'b000;
   localparam logic [2:0] EN_EXTRACT = 3'b001;
   localparam logic [2:0] EN_PREDICT = 3'b010;
   localparam logic [2:0] EN_SAVE    = 3'b100;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/intra_mb_counter.sv
// Raster walker over luma 4x4 blocks; produces registered luma and chroma 8x8 indices.
module intra_mb_counter
   import intra_loop_pkg::*;
#(
   parameter int WIDTH  = 1280,
   parameter int LENGTH = 720
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        step,
   output logic        last,
   output logic [31:0] luma_idx,
   output logic [31:0] chroma_idx
);

   localparam int COLS        = WIDTH / 4;
   localparam int ROWS        = LENGTH / 4;
   localparam int CHROMA_COLS = WIDTH / 8;
   localparam int COL_W       = width_of(COLS);
   localparam int ROW_W       = width_of(ROWS);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [COL_W-1:0] col, col_nxt;
   logic [ROW_W-1:0] row, row_nxt;

   assign last = (col == COL_LAST) && (row == ROW_LAST);

   // Next raster position: clear to origin, or step with column wrap; the last block wraps to 0,0.
   always_comb begin
      col_nxt = col;
      row_nxt = row;
      if (clear) begin
         col_nxt = '0;
         row_nxt = '0;
      end else if (step) begin
         if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
         end else begin
            col_nxt = col + COL_W'(1);
         end
      end
   end

   // Position and both indices are registered together so the indices track col/row exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         luma_idx   <= '0;
         chroma_idx <= '0;
      end else begin
         col        <= col_nxt;
         row        <= row_nxt;
         luma_idx   <= 32'(row_nxt) * 32'(COLS) + 32'(col_nxt);
         chroma_idx <= 32'(row_nxt >> 1) * 32'(CHROMA_COLS) + 32'(col_nxt >> 1);
      end
   end

endmodule

// File: rtl/intra_loop_sequencer.sv
// Per-block extract/predict/save sequencing for the intra reconstructor over one frame.
//
// Upstream handshake: blk_valid is a level meaning the current block's mode/residue are
// stable. It is sampled only in WAIT. Upstream must hold that data until blk_ready, a
// single-cycle pulse in ADVANCE that marks the block consumed; the next block may then
// be presented. Each block is consumed exactly once.
module intra_loop_sequencer
   import intra_loop_pkg::*;
#(
   parameter int WIDTH          = 1280,
   parameter int LENGTH         = 720,
   parameter int EXTRACT_CYCLES = 1,
   parameter int PREDICT_CYCLES = 1,
   parameter int TIMEOUT        = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        blk_valid,
   output logic        blk_ready,
   input  logic        fb_luma4x4,
   input  logic        fb_chromab8x8,
   input  logic        fb_chromar8x8,
   output logic [2:0]  enabler,
   output logic [31:0] mbnumber_luma4x4,
   output logic [31:0] mbnumber_chromab8x8,
   output logic [31:0] mbnumber_chromar8x8,
   output logic        busy,
   output logic        frame_done,
   output logic        timeout_err,
   output seq_state_t  state_dbg
);

   localparam int CNT_W = width_of(max3(EXTRACT_CYCLES, PREDICT_CYCLES, TIMEOUT));

   seq_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       ack_q;
   logic [2:0]       ack_now;
   logic             acks_all;
   logic             mb_clear, mb_step, mb_last;
   logic             timeout_set;
   logic [31:0]      chroma_idx;

   intra_mb_counter #(
      .WIDTH  (WIDTH),
      .LENGTH (LENGTH)
   ) u_mb_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (mb_clear),
      .step       (mb_step),
      .last       (mb_last),
      .luma_idx   (mbnumber_luma4x4),
      .chroma_idx (chroma_idx)
   );

   assign mbnumber_chromab8x8 = chroma_idx;
   assign mbnumber_chromar8x8 = chroma_idx;
   assign state_dbg           = state;

   // An ack counts whether it was latched earlier in SAVE or is arriving this cycle.
   assign ack_now  = ack_q | {fb_chromar8x8, fb_chromab8x8, fb_luma4x4};
   assign acks_all = &ack_now;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and per-state outputs.
   always_comb begin
      state_nxt   = state;
      enabler     = EN_NONE;
      blk_ready   = 1'b0;
      busy        = 1'b1;
      mb_clear    = 1'b0;
      mb_step     = 1'b0;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               mb_clear  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (blk_valid) state_nxt = EXTRACT;
         end
         EXTRACT: begin
            enabler = EN_EXTRACT;
            if (cnt == CNT_W'(EXTRACT_CYCLES - 1)) state_nxt = PREDICT;
         end
         PREDICT: begin
            enabler = EN_PREDICT;
            if (cnt == CNT_W'(PREDICT_CYCLES - 1)) state_nxt = SAVE;
         end
         SAVE: begin
            enabler = EN_SAVE;
            if (acks_all) begin
               state_nxt = ADVANCE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               // Give up on this block and move on; it is not retried.
               timeout_set = 1'b1;
               state_nxt   = ADVANCE;
            end
         end
         ADVANCE: begin
            blk_ready = 1'b1;
            mb_step   = 1'b1;
            state_nxt = mb_last ? IDLE : WAIT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Phase counter: restarts on every state change, counts only in the timed phases.
   always_ff @(posedge clk) begin
      if (reset || (state_nxt != state)) begin
         cnt <= '0;
      end else if ((state == EXTRACT) || (state == PREDICT) || (state == SAVE)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Sticky per-channel ack flags, live only while in SAVE.
   always_ff @(posedge clk) begin
      if (reset || (state != SAVE)) ack_q <= '0;
      else                          ack_q <= ack_now;
   end

   // Sticky timeout flag and the end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_err <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         if ((state == IDLE) && start) timeout_err <= 1'b0;
         else if (timeout_set)         timeout_err <= 1'b1;
         frame_done <= (state == ADVANCE) && mb_last;
      end
   end

endmodule

// File: tb/tb_intra_loop_sequencer.sv
// Self-checking bench for intra_loop_sequencer on a 16x8 frame (4x2 luma grid).
module tb_intra_loop_sequencer;
   import intra_loop_pkg::*;

   localparam int W    = 16;
   localparam int L    = 8;
   localparam int EC   = 1;
   localparam int PC   = 1;
   localparam int TO   = 8;
   localparam int COLS = W / 4;
   localparam int NL   = (W / 4) * (L / 4);
   localparam int CCOLS = W / 8;

   // model phases
   localparam int M_IDLE = 0, M_WAIT = 1, M_EXT = 2, M_PRED = 3, M_SAVE = 4, M_ADV = 5;
   // fb driving policies
   localparam int FB_NOW = 0, FB_STAG = 1, FB_NONE = 2, FB_RAND = 3;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        blk_valid = 1'b0;
   logic        fb_l = 1'b0, fb_b = 1'b0, fb_r = 1'b0;
   logic        blk_ready, busy, frame_done, timeout_err;
   logic [2:0]  enabler;
   logic [31:0] mb_l, mb_b, mb_r;
   seq_state_t  state_dbg;

   always #5 clk = ~clk;

   intra_loop_sequencer #(
      .WIDTH          (W),
      .LENGTH         (L),
      .EXTRACT_CYCLES (EC),
      .PREDICT_CYCLES (PC),
      .TIMEOUT        (TO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .blk_valid           (blk_valid),
      .blk_ready           (blk_ready),
      .fb_luma4x4          (fb_l),
      .fb_chromab8x8       (fb_b),
      .fb_chromar8x8       (fb_r),
      .enabler             (enabler),
      .mbnumber_luma4x4    (mb_l),
      .mbnumber_chromab8x8 (mb_b),
      .mbnumber_chromar8x8 (mb_r),
      .busy                (busy),
      .frame_done          (frame_done),
      .timeout_err         (timeout_err),
      .state_dbg           (state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_phase = M_IDLE;
   int       m_left  = 0;
   int       m_blk   = 0;
   int       m_k     = 0;
   bit [2:0] m_acks  = 3'b000;
   bit       m_terr  = 1'b0;
   bit       m_fdone = 1'b0;

   function automatic logic [31:0] chroma_of(input int b);
      int r, c;
      r = b / COLS;
      c = b % COLS;
      return 32'((r / 2) * CCOLS + c / 2);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_phase = M_IDLE; m_blk = 0; m_terr = 1'b0; m_fdone = 1'b0; m_acks = 3'b000; m_k = 0;
      end else begin
         m_fdone = 1'b0;
         case (m_phase)
            M_IDLE: if (start) begin m_phase = M_WAIT; m_blk = 0; m_terr = 1'b0; end
            M_WAIT: if (blk_valid) begin m_phase = M_EXT; m_left = EC; end
            M_EXT: begin
               m_left--;
               if (m_left == 0) begin m_phase = M_PRED; m_left = PC; end
            end
            M_PRED: begin
               m_left--;
               if (m_left == 0) begin m_phase = M_SAVE; m_acks = 3'b000; m_k = 0; end
            end
            M_SAVE: begin
               m_acks |= {fb_r, fb_b, fb_l};
               m_k++;
               if (m_acks == 3'b111) m_phase = M_ADV;
               else if (m_k == TO) begin m_terr = 1'b1; m_phase = M_ADV; end
            end
            default: begin
               if (m_blk == NL - 1) begin m_fdone = 1'b1; m_blk = 0; m_phase = M_IDLE; end
               else begin m_blk++; m_phase = M_WAIT; end
            end
         endcase
      end
   end

   // Compare DUT outputs with the model every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [2:0] exp_en;
         exp_en = (m_phase == M_EXT)  ? 3'b001 :
                  (m_phase == M_PRED) ? 3'b010 :
                  (m_phase == M_SAVE) ? 3'b100 : 3'b000;
         chk("enabler",     32'(enabler),     32'(exp_en));
         chk("busy",        32'(busy),        32'(m_phase != M_IDLE));
         chk("blk_ready",   32'(blk_ready),   32'(m_phase == M_ADV));
         chk("frame_done",  32'(frame_done),  32'(m_fdone));
         chk("timeout_err", 32'(timeout_err), 32'(m_terr));
         chk("mb_luma",     mb_l,             32'(m_blk));
         chk("mb_chromab",  mb_b,             chroma_of(m_blk));
         chk("mb_chromar",  mb_r,             chroma_of(m_blk));
      end
   end

   // ---------------- observation monitor ----------------
   int          cyc = 0;
   int          last_ready = -1;
   int          ready_cnt = 0;
   int          fdone_cnt = 0;
   int          save_run = 0;
   logic [31:0] obs_luma_q[$];
   logic [31:0] obs_chroma_q[$];
   int          period_q[$];
   int          save_len_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_cq[$];
   int          lit_chroma[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

   always @(negedge clk) begin
      cyc++;
      if (blk_ready === 1'b1) begin
         ready_cnt++;
         obs_luma_q.push_back(mb_l);
         obs_chroma_q.push_back(mb_b);
         if (last_ready >= 0) period_q.push_back(cyc - last_ready);
         last_ready = cyc;
      end
      if (frame_done === 1'b1) fdone_cnt++;
      if (enabler === 3'b100) save_run++;
      else if (save_run > 0) begin
         save_len_q.push_back(save_run);
         save_run = 0;
      end
   end

   // ---------------- stimulus driver ----------------
   int v_mode = 1;        // 0 low, 1 high, 2 random
   int fb_mode = FB_NOW;

   always @(negedge clk) begin
      case (v_mode)
         0:       blk_valid = 1'b0;
         1:       blk_valid = 1'b1;
         default: blk_valid = 1'($urandom_range(0, 1));
      endcase
      fb_l = 1'b0; fb_b = 1'b0; fb_r = 1'b0;
      case (fb_mode)
         FB_NOW: if (m_phase == M_SAVE && m_k == 0) begin fb_l = 1'b1; fb_b = 1'b1; fb_r = 1'b1; end
         FB_STAG: if (m_phase == M_SAVE) begin
            fb_l = (m_k == 1);
            fb_b = (m_k == 3);
            fb_r = (m_k == 5);
         end
         FB_NONE: ;
         default: begin
            fb_l = ($urandom_range(0, 2) == 0);
            fb_b = ($urandom_range(0, 2) == 0);
            fb_r = ($urandom_range(0, 2) == 0);
         end
      endcase
   end

   // ---------------- tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_obs();
      obs_luma_q.delete();
      obs_chroma_q.delete();
      period_q.delete();
      save_len_q.delete();
      ready_cnt = 0;
      fdone_cnt = 0;
      last_ready = -1;
   endtask

   task automatic wait_frame(input string name, input int bound);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL %s frame_done actual=absent required=within_%0d_cycles", name, bound);
      end
   endtask

   task automatic check_luma_seq(input string name, input bit with_chroma);
      exp_q.delete();
      exp_cq.delete();
      for (int i = 0; i < NL; i++) begin
         exp_q.push_back(32'(i));
         exp_cq.push_back(32'(lit_chroma[i]));
      end
      chk({name, "_count"}, 32'(obs_luma_q.size()), 32'(NL));
      while (obs_luma_q.size() > 0 && exp_q.size() > 0) begin
         logic [31:0] c_obs, c_exp;
         chk({name, "_luma"}, obs_luma_q.pop_front(), exp_q.pop_front());
         c_obs = obs_chroma_q.pop_front();
         c_exp = exp_cq.pop_front();
         if (with_chroma) chk({name, "_chroma"}, c_obs, c_exp);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      repeat (2) tick();
      chk("reset_enabler", 32'(enabler), 32'd0);
      chk("reset_busy",    32'(busy),    32'd0);
      chk("reset_luma",    mb_l,         32'd0);
      chk("reset_chroma",  mb_b,         32'd0);
      chk("reset_terr",    32'(timeout_err), 32'd0);
      reset = 1'b0;
      tick();

      // 1: back-to-back blocks, fb in the first SAVE cycle
      clear_obs();
      v_mode = 1; fb_mode = FB_NOW;
      pulse_start();
      wait_frame("t1_frame", 200);
      chk("t1_ready_pulses", 32'(ready_cnt), 32'd8);
      chk("t1_frame_done_pulses", 32'(fdone_cnt), 32'd1);
      check_luma_seq("t1", 1'b1);
      chk("t1_period_count", 32'(period_q.size()), 32'd7);
      foreach (period_q[i]) chk("t1_block_period", 32'(period_q[i]), 32'd5);
      foreach (save_len_q[i]) chk("t1_save_len", 32'(save_len_q[i]), 32'd1);

      // 2: blk_valid held low in WAIT
      clear_obs();
      v_mode = 0;
      pulse_start();
      repeat (10) begin
         chk("t2_wait_enabler", 32'(enabler),   32'd0);
         chk("t2_wait_ready",   32'(blk_ready), 32'd0);
         chk("t2_wait_busy",    32'(busy),      32'd1);
         tick();
      end
      v_mode = 1;
      tick();
      chk("t2_still_wait", 32'(enabler), 32'd0);
      tick();
      chk("t2_extract_next", 32'(enabler), 32'b001);
      wait_frame("t2_frame", 200);

      // 3: staggered single-cycle acks
      clear_obs();
      fb_mode = FB_STAG;
      pulse_start();
      wait_frame("t3_frame", 400);
      chk("t3_save_count", 32'(save_len_q.size()), 32'd8);
      foreach (save_len_q[i]) chk("t3_save_len", 32'(save_len_q[i]), 32'd6);
      chk("t3_no_timeout", 32'(timeout_err), 32'd0);

      // 4: no acks at all, every block times out
      clear_obs();
      fb_mode = FB_NONE;
      pulse_start();
      wait_frame("t4_frame", 400);
      chk("t4_save_count", 32'(save_len_q.size()), 32'd8);
      foreach (save_len_q[i]) chk("t4_save_len", 32'(save_len_q[i]), 32'd8);
      chk("t4_timeout_set", 32'(timeout_err), 32'd1);
      check_luma_seq("t4", 1'b0);
      fb_mode = FB_NOW;
      pulse_start();
      chk("t4_start_clears_terr", 32'(timeout_err), 32'd0);
      wait_frame("t4_frame2", 200);

      // 5: reset during PREDICT of block 5
      clear_obs();
      pulse_start();
      begin
         int n;
         n = 0;
         while (!(m_phase == M_PRED && m_blk == 5) && n < 200) begin tick(); n++; end
         chk("t5_reached_predict5", 32'(m_phase == M_PRED && m_blk == 5), 32'd1);
      end
      reset = 1'b1;
      tick();
      chk("t5_enabler", 32'(enabler), 32'd0);
      chk("t5_busy",    32'(busy),    32'd0);
      chk("t5_luma",    mb_l,         32'd0);
      chk("t5_chromab", mb_b,         32'd0);
      chk("t5_chromar", mb_r,         32'd0);
      reset = 1'b0;
      tick();
      clear_obs();
      pulse_start();
      wait_frame("t5_frame", 200);
      check_luma_seq("t5", 1'b1);

      // 6: start while busy is ignored
      clear_obs();
      pulse_start();
      begin
         int n;
         n = 0;
         while (!(m_phase == M_EXT && m_blk == 3) && n < 200) begin tick(); n++; end
      end
      pulse_start();
      wait_frame("t6_frame", 200);
      repeat (20) tick();
      chk("t6_single_frame_done", 32'(fdone_cnt), 32'd1);
      chk("t6_idle_after", 32'(busy), 32'd0);
      check_luma_seq("t6", 1'b0);

      // 7: randomized valid and acks
      v_mode = 2;
      fb_mode = FB_RAND;
      repeat (3) begin
         clear_obs();
         pulse_start();
         wait_frame("t7_frame", 600);
         chk("t7_ready_pulses", 32'(ready_cnt), 32'd8);
         repeat ($urandom_range(1, 4)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop if the sequence above ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
